// File: rtl/taylor_pkg.sv
// Shared types and constants for the Taylor-series engine: mode/state enums,
// inverse-factorial coefficient generator and multiplier cycle count.
package taylor_pkg;

  typedef enum logic [1:0] {
    MODE_COS  = 2'd0,
    MODE_SIN  = 2'd1,
    MODE_EXP  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SQ   = 3'd1,
    ST_COEF = 3'd2,
    ST_POW  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // One start cycle plus one Booth iteration per multiplier bit.
  function automatic int unsigned mul_cyc(input int unsigned width);
    return width + 1;
  endfunction

  localparam int unsigned MUL_CYC = mul_cyc(17);

  // round(2**frac / n!), evaluated at elaboration to fill the coefficient ROM.
  function automatic longint unsigned inv_fact(input int unsigned n, input int unsigned frac);
    longint unsigned f;
    f = 64'd1;
    for (int unsigned i = 2; i <= n; i++) begin
      f = f * 64'(i);
    end
    return ((64'd1 << frac) + (f >> 1)) / f;
  endfunction

endpackage

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier for unsigned operands: one load cycle,
// then WIDTH iterations; done pulses for one cycle with product valid.
module booth_mul_seq #(
  parameter int unsigned WIDTH = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [PW-1:0] mcand;
  logic [PW-1:0] acc;
  logic [PW-1:0] acc_step;
  logic [WIDTH-1:0] mplier;
  logic          prev;
  logic          last;

  assign last = (cnt == CW'(WIDTH - 1));

  // Modular arithmetic is exact: the final sum is the non-negative product.
  // The last step also applies the implicit top recoding digit of the
  // zero-extended multiplier.
  always_comb begin
    acc_step = acc;
    case ({mplier[0], prev})
      2'b01:   acc_step = acc + mcand;
      2'b10:   acc_step = acc - mcand;
      default: acc_step = acc;
    endcase
    if (last && mplier[0]) begin
      acc_step = acc_step + (mcand << 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prev   <= 1'b0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      done   <= 1'b0;
      cnt    <= '0;
      mcand  <= PW'(a);
      mplier <= b;
      prev   <= 1'b0;
      acc    <= '0;
    end else if (busy) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      prev   <= mplier[0];
      cnt    <= cnt + CW'(1);
      busy   <= !last;
      done   <= last;
    end else begin
      done   <= 1'b0;
    end
  end

  assign product = acc;

endmodule

// File: rtl/taylor_series_engine.sv
// Fixed-point Taylor-series evaluator (cos/sin/exp) on one shared sequential
// multiplier. Optional macro TAYLOR_EARLY_EXIT_EN stops at the first zero term.
import taylor_pkg::*;

module taylor_series_engine #(
  parameter int unsigned WIDTH   = 17,
  parameter int unsigned FRAC    = 16,
  parameter int unsigned N_TERMS = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH+1:0]   out_data,
  output logic               out_err
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned AW    = WIDTH + 2;
  localparam int unsigned ROM_N = 2 * N_TERMS;
  localparam int unsigned NW    = $clog2(ROM_N);
  localparam int unsigned KW    = $clog2(N_TERMS);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(64'd1 << FRAC);

  state_t state_q, state_d;
  mode_t  mode_q, mode_d;
  logic [WIDTH-1:0] x_q, x_d, x2_q, x2_d, power_q, power_d;
  logic [NW-1:0]    n_q, n_d, n_inc;
  logic [KW-1:0]    k_q, k_d;
  logic signed [AW-1:0] acc_q, acc_d, acc_sum, term_s;
  logic             err_q, err_d;
  logic             in_ready_d, out_valid_d, out_err_d;
  logic [AW-1:0]    out_data_d;

  logic             mul_start_c, mul_done;
  logic [WIDTH-1:0] mul_a_c, mul_b_c;
  logic [PW-1:0]    mul_product, prod_shift;
  logic [WIDTH-1:0] term;
  logic             unused_hi;
  logic             neg, last, stop, bad;

  logic [WIDTH-1:0] coef_rom [ROM_N];
  for (genvar g = 0; g < ROM_N; g++) begin : g_rom
    assign coef_rom[g] = WIDTH'(inv_fact(g, FRAC));
  end

  booth_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_c),
    .a       (mul_a_c),
    .b       (mul_b_c),
    .done    (mul_done),
    .product (mul_product)
  );

  // Floor truncation back to Q.FRAC; powers stay below 1.0 so the high bits are zero.
  assign prod_shift = mul_product >> FRAC;
  assign term       = prod_shift[WIDTH-1:0];
  assign unused_hi  = ^prod_shift[PW-1:WIDTH];

  assign term_s  = $signed({2'b00, term});
  assign neg     = (mode_q != MODE_EXP) && k_q[0];
  assign acc_sum = neg ? (acc_q - term_s) : (acc_q + term_s);
  assign n_inc   = n_q + ((mode_q == MODE_EXP) ? NW'(1) : NW'(2));
  assign last    = (k_q == KW'(N_TERMS - 1));
  assign bad     = (in_x >= ONE) || (mode_t'(in_mode) == MODE_RSVD);

`ifdef TAYLOR_EARLY_EXIT_EN
  assign stop = last || (term == '0);
`else
  assign stop = last;
`endif

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    x_d         = x_q;
    x2_d        = x2_q;
    power_d     = power_q;
    n_d         = n_q;
    k_d         = k_q;
    acc_d       = acc_q;
    err_d       = err_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_err_d   = out_err;
    mul_start_c = 1'b0;
    mul_a_c     = power_q;
    mul_b_c     = coef_rom[n_q];

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          x_d    = in_x;
          mode_d = mode_t'(in_mode);
          err_d  = bad;
          acc_d  = '0;
          k_d    = '0;
          if (bad) begin
            state_d = ST_SQ;
          end else if (mode_t'(in_mode) == MODE_EXP) begin
            power_d     = ONE;
            n_d         = '0;
            state_d     = ST_COEF;
            mul_start_c = 1'b1;
            mul_a_c     = ONE;
            mul_b_c     = coef_rom[0];
          end else begin
            power_d     = (mode_t'(in_mode) == MODE_SIN) ? in_x : ONE;
            n_d         = (mode_t'(in_mode) == MODE_SIN) ? NW'(1) : NW'(0);
            state_d     = ST_SQ;
            mul_start_c = 1'b1;
            mul_a_c     = in_x;
            mul_b_c     = in_x;
          end
        end
      end
      // Rejected requests pass through here for one cycle without multiplying.
      ST_SQ: begin
        if (err_q) begin
          state_d = ST_DONE;
        end else if (mul_done) begin
          x2_d        = term;
          state_d     = ST_COEF;
          mul_start_c = 1'b1;
          mul_a_c     = power_q;
          mul_b_c     = coef_rom[n_q];
        end
      end
      ST_COEF: begin
        if (mul_done) begin
          acc_d = acc_sum;
          if (stop) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_POW;
            mul_start_c = 1'b1;
            mul_a_c     = power_q;
            mul_b_c     = (mode_q == MODE_EXP) ? x_q : x2_q;
          end
        end
      end
      ST_POW: begin
        if (mul_done) begin
          power_d     = term;
          n_d         = n_inc;
          k_d         = k_q + KW'(1);
          state_d     = ST_COEF;
          mul_start_c = 1'b1;
          mul_a_c     = term;
          mul_b_c     = coef_rom[n_inc];
        end
      end
      ST_DONE: begin
        out_data_d = err_q ? '0 : AW'(acc_q);
        out_err_d  = err_q;
        if (out_valid && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_COS;
      x_q       <= '0;
      x2_q      <= '0;
      power_q   <= '0;
      n_q       <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      err_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      x_q       <= x_d;
      x2_q      <= x2_d;
      power_q   <= power_d;
      n_q       <= n_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      err_q     <= err_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_err   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_taylor_series_engine.sv
// Directed-vector bench for taylor_series_engine: reset, cos/sin/exp values,
// exact latency, error paths, output hold, back-to-back and mid-run reset.
module tb_taylor_series_engine;

  localparam int LAT_EXP  = 17 * 18 + 1;
  localparam int LAT_TRIG = 18 * 18 + 1;
  localparam int TOL      = 16;
  localparam logic [1:0] M_COS = 2'd0;
  localparam logic [1:0] M_SIN = 2'd1;
  localparam logic [1:0] M_EXP = 2'd2;
  localparam logic [1:0] M_RSV = 2'd3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [16:0]        in_x;
  logic [1:0]         in_mode;
  logic               out_valid;
  logic               out_ready;
  logic signed [18:0] out_data;
  logic               out_err;

  int n_checks = 0;
  int n_fail   = 0;

  taylor_series_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  // Present one request, then count edges from the accept edge to out_valid.
  task automatic run_req(input logic [16:0] x, input logic [1:0] m, output int cyc);
    int guard;
    guard = 0;
    @(negedge clk);
    in_x = x; in_mode = m; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL timeout waiting for out_valid x=%0d mode=%0d", x, m);
    end
  endtask

  task automatic ack;
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_mode = '0; out_ready = 1'b0;
    #23;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 19'sd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err got %b want 0", out_err); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_main_values;
    int cyc, d;
    logic [1:0] modes [3];
    int exps [3];
    int lats [3];
    modes = '{M_COS, M_SIN, M_EXP};
    exps  = '{39936, 51963, 163716};
    lats  = '{LAT_TRIG, LAT_TRIG, LAT_EXP};
    for (int i = 0; i < 3; i++) begin
      run_req(17'd60000, modes[i], cyc);
      d = int'(out_data);
      n_checks++;
      if (d - exps[i] > TOL || exps[i] - d > TOL) begin
        n_fail++; $display("FAIL value_mode%0d got %0d want %0d+-%0d", modes[i], d, exps[i], TOL);
      end
      n_checks++;
      if (out_err !== 1'b0) begin n_fail++; $display("FAIL err_mode%0d got %b want 0", modes[i], out_err); end
`ifndef TAYLOR_EARLY_EXIT_EN
      n_checks++;
      if (cyc != lats[i]) begin n_fail++; $display("FAIL latency_mode%0d got %0d want %0d", modes[i], cyc, lats[i]); end
`endif
      ack();
    end
  endtask

  task automatic test_zero;
    int cyc;
    logic [1:0] modes [3];
    logic signed [18:0] exps [3];
    modes = '{M_COS, M_SIN, M_EXP};
    exps  = '{19'sd65536, 19'sd0, 19'sd65536};
    for (int i = 0; i < 3; i++) begin
      run_req(17'd0, modes[i], cyc);
      n_checks++;
      if (out_data !== exps[i]) begin
        n_fail++; $display("FAIL zero_mode%0d got %0d want %0d", modes[i], out_data, exps[i]);
      end
      ack();
    end
  endtask

  task automatic test_error;
    int cyc;
    logic [16:0] xs [2];
    logic [1:0]  ms [2];
    xs = '{17'd65536, 17'd60000};
    ms = '{M_COS, M_RSV};
    for (int i = 0; i < 2; i++) begin
      run_req(xs[i], ms[i], cyc);
      n_checks++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL err_flag_%0d got %b want 1", i, out_err); end
      n_checks++; if (out_data !== 19'sd0) begin n_fail++; $display("FAIL err_data_%0d got %0d want 0", i, out_data); end
      n_checks++; if (cyc != 2) begin n_fail++; $display("FAIL err_latency_%0d got %0d want 2", i, cyc); end
      ack();
    end
  endtask

  task automatic test_back_to_back;
    int cyc, d;
    run_req(17'd0, M_COS, cyc);
    @(negedge clk);
    in_x = 17'd60000; in_mode = M_EXP; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 19'sd65536 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d got valid=%b data=%0d ready=%b want 1/65536/0", i, out_valid, out_data, in_ready);
      end
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL after_ack got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got ready=%b want 0", in_ready); end
    cyc = 0;
    while (!out_valid && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    d = int'(out_data);
    n_checks++;
    if (d - 163716 > TOL || 163716 - d > TOL) begin
      n_fail++; $display("FAIL b2b_value got %0d want 163716+-%0d", d, TOL);
    end
`ifndef TAYLOR_EARLY_EXIT_EN
    n_checks++;
    if (cyc != LAT_EXP) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", cyc, LAT_EXP); end
`endif
    ack();
  endtask

  task automatic test_reset_mid;
    int cyc, d;
    @(negedge clk);
    in_x = 17'd60000; in_mode = M_COS; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    run_req(17'd60000, M_SIN, cyc);
    d = int'(out_data);
    n_checks++;
    if (d - 51963 > TOL || 51963 - d > TOL) begin
      n_fail++; $display("FAIL post_reset_value got %0d want 51963+-%0d", d, TOL);
    end
    ack();
  endtask

  task automatic test_small_x;
    int cyc;
    run_req(17'd1000, M_COS, cyc);
    n_checks++;
    if (out_data !== 19'sd65529) begin n_fail++; $display("FAIL small_x_value got %0d want 65529", out_data); end
    n_checks++;
`ifdef TAYLOR_EARLY_EXIT_EN
    if (cyc >= LAT_TRIG) begin n_fail++; $display("FAIL small_x_latency got %0d want <%0d", cyc, LAT_TRIG); end
`else
    if (cyc != LAT_TRIG) begin n_fail++; $display("FAIL small_x_latency got %0d want %0d", cyc, LAT_TRIG); end
`endif
    ack();
  endtask

  initial begin
    test_reset();
    test_main_values();
    test_zero();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_small_x();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
